// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the mem load/store unit.
// Optional define SRAM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_BUS      = 32,
  parameter int DATA_BUS      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_i,
  input  logic                req1_i,
  input  logic                we0_i,
  input  logic                we1_i,
  input  logic [ADDR_BUS-1:0] addr0_i,
  input  logic [ADDR_BUS-1:0] addr1_i,
  input  logic [3:0]          width0_i,
  input  logic [3:0]          width1_i,
  input  logic [DATA_BUS-1:0] wdata0_i,
  input  logic [DATA_BUS-1:0] wdata1_i,
  output logic                gnt0_o,
  output logic                gnt1_o,
  output logic                done0_o,
  output logic                done1_o,
  output logic [DATA_BUS-1:0] rdata0_o,
  output logic [DATA_BUS-1:0] rdata1_o,
  output logic                err0_o,
  output logic                err1_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_BUS-1:0] mem_addr_o,
  output logic [3:0]          mem_width_o,
  output logic [DATA_BUS-1:0] mem_data_o,
  input  logic [DATA_BUS-1:0] mem_data_i,
  output logic [1:0]          dbg_state_o
);

  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;
  localparam logic [3:0]          CNT_LOAD  = 4'(ACCESS_CYCLES - 1);

  // Handshake: a requester holds reqN and its fields stable until gntN pulses;
  // doneN pulses once per granted transaction, and reqN may drop in that cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                last;
  logic                win;
  logic                lat_we;
  logic [ADDR_BUS-1:0] lat_addr;
  logic [3:0]          lat_width;
  logic [DATA_BUS-1:0] lat_wdata;
  logic                legal_q;

  logic                any_req;
  logic                tie_pick;
  logic                pick;
  logic                pick_we;
  logic [ADDR_BUS-1:0] pick_addr;
  logic [3:0]          pick_width;
  logic [DATA_BUS-1:0] pick_wdata;
  logic                pick_legal;

  function automatic logic is_legal(input logic [3:0] width, input logic [1:0] lsb);
    case (width)
      4'd1:    is_legal = 1'b1;
      4'd2:    is_legal = (lsb[0] == 1'b0);
      4'd4:    is_legal = (lsb == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  assign tie_pick = ~last;
`endif

  assign any_req    = req0_i | req1_i;
  // With a single requester it wins outright; ~req0 selects port 1 in that case.
  assign pick       = (req0_i & req1_i) ? tie_pick : ~req0_i;
  assign pick_we    = pick ? we1_i    : we0_i;
  assign pick_addr  = pick ? addr1_i  : addr0_i;
  assign pick_width = pick ? width1_i : width0_i;
  assign pick_wdata = pick ? wdata1_i : wdata0_i;
  assign pick_legal = is_legal(pick_width, pick_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_width <= 4'd0;
      lat_wdata <= '0;
      legal_q   <= 1'b0;
      gnt0_o    <= 1'b0;
      gnt1_o    <= 1'b0;
      rdata0_o  <= ZERO_WORD;
      rdata1_o  <= ZERO_WORD;
    end else begin
      state  <= state_nxt;
      gnt0_o <= 1'b0;
      gnt1_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win       <= pick;
            lat_we    <= pick_we;
            lat_addr  <= pick_addr;
            lat_width <= pick_width;
            lat_wdata <= pick_wdata;
            legal_q   <= pick_legal;
            cnt       <= CNT_LOAD;
            gnt0_o    <= ~pick;
            gnt1_o    <= pick;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!legal_q) begin
              if (win) rdata1_o <= ZERO_WORD;
              else     rdata0_o <= ZERO_WORD;
            end else if (!lat_we) begin
              if (win) rdata1_o <= mem_data_i;
              else     rdata0_o <= mem_data_i;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: last <= win;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An illegal request still occupies the access window, but never strobes mem.
  assign mem_ce_o    = (state == ACCESS) && legal_q;
  assign mem_we_o    = mem_ce_o & lat_we;
  assign mem_addr_o  = mem_ce_o ? lat_addr  : '0;
  assign mem_width_o = mem_ce_o ? lat_width : 4'd0;
  assign mem_data_o  = mem_ce_o ? lat_wdata : '0;

  assign done0_o     = (state == DONE) && !win;
  assign done1_o     = (state == DONE) && win;
  assign err0_o      = done0_o && !legal_q;
  assign err1_o      = done1_o && !legal_q;
  assign dbg_state_o = state;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and sequencer in front of the `mem` load/store unit. It accepts read/write requests from two switch-side masters, selects one per transaction, and drives `mem`'s ce/we/addr/width/data inputs from latched copies for a fixed number of access cycles. It returns read data and a done pulse to the winning requester. Masters no longer drive `mem` combinationally; all SRAM traffic is serialized here.

## Interface
- `ACCESS_CYCLES`, default 2: cycles `mem_ce` is held per transaction; legal range 1..15.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req0_i` / `req1_i`  input  1  request valid from port 0 / port 1.
- `we0_i` / `we1_i`  input  1  1 = store, 0 = load.
- `addr0_i` / `addr1_i`  input  `ADDR_BUS`  byte address.
- `width0_i` / `width1_i`  input  4  access width in bytes: 1, 2 or 4.
- `wdata0_i` / `wdata1_i`  input  `DATA_BUS`  store data, right-aligned.
- `gnt0_o` / `gnt1_o`  output  1  one-cycle pulse: request fields latched.
- `done0_o` / `done1_o`  output  1  one-cycle pulse: transaction complete.
- `rdata0_o` / `rdata1_o`  output  `DATA_BUS`  load result; held until that port's next done.
- `err0_o` / `err1_o`  output  1  valid with done: illegal width or misaligned address.
- `mem_ce_o`, `mem_we_o`  output  1  to `mem` ce/we.
- `mem_addr_o`  output  `ADDR_BUS`  to `mem` addr_i.
- `mem_width_o`  output  4  to `mem` width_i.
- `mem_data_o`  output  `DATA_BUS`  to `mem` data_i.
- `mem_data_i`  input  `DATA_BUS`  from `mem` data_o.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE with no request: stay in IDLE; all `mem_*` outputs are 0.
- IDLE with any `reqN_i`:
  - Choose a winner; latch its we/addr/width/wdata.
  - Pulse `gntN_o`.
  - Load counter with `ACCESS_CYCLES-1` and go to ACCESS.
- Arbitration is round-robin. A `last` register records the last served port. When both ports request, the port that is not `last` wins. After reset `last`=1, so port 0 wins the first tie.
- ACCESS with a legal request:
  - Drive `mem_ce_o`=1 and the latched we/addr/width/data.
  - Decrement the counter each cycle.
  - When the counter is 0, register `mem_data_i` into the winner's `rdata` (loads only; stores leave `rdata` unchanged) and go to DONE.
- Legality check:
  - Illegal: width not in {1,2,4}; width 2 with `addr[0]`=1; width 4 with `addr[1:0]`≠0.
  - An illegal request still spends ACCESS cycles, but `mem_ce_o` stays 0.
  - Its `rdata` is set to `ZERO_WORD` and `err` is set with done.
- DONE:
  - Pulse the winner's `doneN_o` (plus `errN_o` if applicable).
  - Update `last`; return to IDLE.
  - No grant is issued in this state.
- Requester rules:
  - Hold `req` and fields stable from assertion until `gnt`; fields may change after `gnt`.
  - Deassert `req` in the cycle `done` is seen, or keep it high with new fields for a back-to-back request.
- Reset: asynchronous `rst_n`=0 forces state to IDLE, counter 0, `last`=1. It also zeroes every output and every latched register. An in-flight transaction is abandoned with no done.

## Timing
- Request sampled in IDLE at edge T: `gnt` high in T+1, `mem_ce_o` high in T+1 .. T+ACCESS_CYCLES.
- `done` and `rdata` visible in T+ACCESS_CYCLES+1.
- Earliest next grant is at T+ACCESS_CYCLES+2, so sustained throughput is one transaction per ACCESS_CYCLES+2 cycles.
- All outputs are registered or decoded from state and latched registers only; there are no combinational paths from `reqN_i`.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: port 0 always wins a tie; `last` still updates but is ignored.
- `SRAM_ARB_FIXED_PRIO_EN` undefined: round-robin as described above.

## Test plan
- Reset, then `req0` load addr 0x10, width 4, ACCESS_CYCLES=2, `mem_data_i`=0xDEADBEEF:
  - `gnt0` in cycle 1; `mem_ce_o` in cycles 1–2.
  - `done0` in cycle 3 with `rdata0_o`=0xDEADBEEF.
- Both ports issue continuous requests for 3 transactions:
  - Round-robin: grant order 0,1,0.
  - With `SRAM_ARB_FIXED_PRIO_EN`: grant order 0,0,0.
- `req1` store width 1, addr 0x3, data 0xAB: `mem_we_o`=1, `mem_width_o`=1, `mem_addr_o`=0x3, `mem_data_o`=0xAB; `done1`, `err1`=0, `rdata1_o` unchanged.
- `req0` load width 4, addr 0x2: `mem_ce_o` never asserts; `done0` and `err0` pulse; `rdata0_o`=0.
- `rst_n` dropped during ACCESS:
  - Outputs zero immediately; no done is issued.
  - After release, a pending `req1` tie with `req0` grants port 0 first.
